satd_block_feeder: RTL and testbench

- Supplies 4x4 SATD blocks to the SATD datapath: 16 original/candidate pixel pairs per block.
- Upstream pushes pairs over a valid/ready handshake into a two-bank ping-pong buffer.
- The drain side answers the SATD control FSM: it advances one pair per cycle while ENABLE_COUNTER is high and returns the 4-bit sample counter that the control FSM watches for 15.
- Sits between the pixel fetch logic and the difference stage.

---
 rtl/satd_block_feeder.sv | 148 ++++++++++++++
 tb/tb_satd_block_feeder.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/satd_block_feeder.sv
// satd_block_feeder
// Two-bank ping-pong buffer that collects 16 original/candidate pixel pairs
// per 4x4 block from upstream and replays them, one pair per enabled cycle,
// to the SATD difference stage under control of the SATD control FSM.
//
// Ports:
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   in_valid        upstream pair valid
//   in_ready        feeder can accept a pair this cycle (write bank not full)
//   in_orig/in_cand incoming original / candidate pixel
//   ENABLE_COUNTER  advance request from SATD control
//   counter         index (0..15) of the pair currently presented
//   out_valid       a full block is being presented
//   out_orig/out_cand pixel pair at counter (zero while not presenting)
//   block_last      high in the cycle the pair at index 15 is consumed
//   underrun        sticky: advance requested while no block was available
module satd_block_feeder #(
  parameter int PIXEL_WIDTH   = 8,
  parameter int BLOCK_SAMPLES = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PIXEL_WIDTH-1:0] in_orig,
  input  logic [PIXEL_WIDTH-1:0] in_cand,
  input  logic                   ENABLE_COUNTER,
  output logic [3:0]             counter,
  output logic                   out_valid,
  output logic [PIXEL_WIDTH-1:0] out_orig,
  output logic [PIXEL_WIDTH-1:0] out_cand,
  output logic                   block_last,
  output logic                   underrun
);

  localparam logic [3:0] LAST_IDX = 4'(BLOCK_SAMPLES - 1);
  localparam int         PAIR_W   = 2 * PIXEL_WIDTH;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t            state_r;
  // Entry address is {bank, index}; each entry holds {orig, cand}.
  logic [PAIR_W-1:0] mem_r [0:31];
  logic [1:0]        full_r;
  logic [1:0]        full_next_s;
  logic              wr_bank_r;
  logic              rd_bank_r;
  logic [3:0]        wr_idx_r;
  logic [3:0]        counter_r;
  logic              underrun_r;

  logic              draining_s;
  logic              wr_fire_s;
  logic              set_full_s;
  logic              rd_fire_s;
  logic              clr_full_s;
  logic [PAIR_W-1:0] rd_pair_s;

  // Handshake decode, full-flag next state and read-data selection.
  always_comb begin
    draining_s = (state_r == DRAIN);
    wr_fire_s  = in_valid && !full_r[wr_bank_r];
    set_full_s = wr_fire_s && (wr_idx_r == LAST_IDX);
    rd_fire_s  = draining_s && ENABLE_COUNTER;
    clr_full_s = rd_fire_s && (counter_r == LAST_IDX);
    // Set and clear can hit different banks in the same cycle; the same bank
    // cannot be both written and freed because a full bank refuses writes.
    full_next_s[0] = (set_full_s && !wr_bank_r) ||
                     (full_r[0] && !(clr_full_s && !rd_bank_r));
    full_next_s[1] = (set_full_s && wr_bank_r) ||
                     (full_r[1] && !(clr_full_s && rd_bank_r));
    // Data is forced to zero outside DRAIN so stale buffer contents never leak.
    rd_pair_s  = draining_s ? mem_r[{rd_bank_r, counter_r}] : {PAIR_W{1'b0}};
  end

  assign in_ready   = !full_r[wr_bank_r];
  assign out_valid  = draining_s;
  assign counter    = counter_r;
  assign out_orig   = rd_pair_s[PAIR_W-1:PIXEL_WIDTH];
  assign out_cand   = rd_pair_s[PIXEL_WIDTH-1:0];
  assign block_last = clr_full_s;
  assign underrun   = underrun_r;

  // Pair storage; contents are don't-care after reset so no reset is applied.
  always_ff @(posedge clk) begin
    if (wr_fire_s) begin
      mem_r[{wr_bank_r, wr_idx_r}] <= {in_orig, in_cand};
    end
  end

  // Write pointer, write bank and per-bank full flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank_r <= 1'b0;
      wr_idx_r  <= 4'd0;
      full_r    <= 2'b00;
    end else begin
      full_r <= full_next_s;
      if (wr_fire_s) begin
        wr_idx_r <= (wr_idx_r == LAST_IDX) ? 4'd0 : wr_idx_r + 4'd1;
        if (set_full_s) begin
          wr_bank_r <= !wr_bank_r;
        end
      end
    end
  end

  // Read FSM: sample counter, read bank and sticky underrun flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      counter_r  <= 4'd0;
      rd_bank_r  <= 1'b0;
      underrun_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (ENABLE_COUNTER) begin
            underrun_r <= 1'b1;
          end
          // Uses the registered flag: one cycle from fill completion to valid.
          if (full_r[rd_bank_r]) begin
            state_r <= DRAIN;
          end
        end
        DRAIN: begin
          if (ENABLE_COUNTER) begin
            if (counter_r == LAST_IDX) begin
              counter_r <= 4'd0;
              rd_bank_r <= !rd_bank_r;
              // Stay in DRAIN when the other bank is ready: no bubble.
              state_r   <= full_r[!rd_bank_r] ? DRAIN : IDLE;
            end else begin
              counter_r <= counter_r + 4'd1;
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_satd_block_feeder.sv
// tb_satd_block_feeder
// Self-checking bench for satd_block_feeder. Inputs change 1 time unit after
// each rising edge; everything is sampled on the falling edge. A monitor
// process keeps a queue of accepted pairs plus accepted/consumed counts, and
// checks in_ready, block_last, counter and pixel data whenever a pair is
// consumed. Directed sequences add timing checks around the reference rules.
module tb_satd_block_feeder;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_orig;
  logic [7:0] in_cand;
  logic       ENABLE_COUNTER;
  logic [3:0] counter;
  logic       out_valid;
  logic [7:0] out_orig;
  logic [7:0] out_cand;
  logic       block_last;
  logic       underrun;

  int tests = 0;
  int fails = 0;

  logic [15:0] sb_q[$];
  int          acc_cnt = 0;
  int          con_cnt = 0;

  logic [7:0] st_o [0:15];
  logic [7:0] st_c [0:15];

  satd_block_feeder #(.PIXEL_WIDTH(8), .BLOCK_SAMPLES(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_orig        (in_orig),
    .in_cand        (in_cand),
    .ENABLE_COUNTER (ENABLE_COUNTER),
    .counter        (counter),
    .out_valid      (out_valid),
    .out_orig       (out_orig),
    .out_cand       (out_cand),
    .block_last     (block_last),
    .underrun       (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Call at posedge+1; holds the pair until the DUT takes it.
  task automatic push(input logic [7:0] o, input logic [7:0] c);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_orig  = o;
    in_cand  = c;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      tests++;
      fails++;
      $display("FAIL push_timeout: in_ready stayed 0 for %0d cycles", n);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Call at posedge+1; holds ENABLE_COUNTER for n rising edges.
  task automatic run_en(input int n);
    ENABLE_COUNTER = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    ENABLE_COUNTER = 1'b0;
  endtask

  // Scoreboard: reference rules are "a bank is full from its 16th accepted
  // pair until its 16th consumed pair", and pairs come out in arrival order.
  initial begin
    logic        exp_ready;
    logic        cons;
    int          idx;
    logic [15:0] p;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb_q.delete();
        acc_cnt = 0;
        con_cnt = 0;
      end else begin
        exp_ready = ((acc_cnt / 16) - (con_cnt / 16)) < 2;
        chk("in_ready", in_ready, exp_ready);
        cons = out_valid && ENABLE_COUNTER;
        idx  = con_cnt % 16;
        chk("block_last", block_last, cons && (idx == 15));
        if (cons) begin
          if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL pop_empty: consumption with no pair expected, counter=%0d", counter);
          end else begin
            p = sb_q.pop_front();
            chk("counter", counter, idx);
            chk("out_orig", out_orig, p[15:8]);
            chk("out_cand", out_cand, p[7:0]);
          end
          con_cnt++;
        end
        if (in_valid && exp_ready) begin
          sb_q.push_back({in_orig, in_cand});
          acc_cnt++;
        end
      end
    end
  end

  initial begin
    int n;
    rst_n          = 1'b0;
    in_valid       = 1'b0;
    in_orig        = 8'd0;
    in_cand        = 8'd0;
    ENABLE_COUNTER = 1'b0;

    // Reset values
    #12;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_block_last", block_last, 1'b0);
    chk("rst_underrun", underrun, 1'b0);
    chk("rst_counter", counter, 4'd0);
    chk("rst_out_orig", out_orig, 8'd0);
    chk("rst_out_cand", out_cand, 8'd0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Underrun: enable with nothing buffered
    ENABLE_COUNTER = 1'b1;
    @(negedge clk);
    chk("udr_before", underrun, 1'b0);
    @(posedge clk);
    #1;
    ENABLE_COUNTER = 1'b0;
    @(negedge clk);
    chk("udr_set", underrun, 1'b1);
    chk("udr_counter", counter, 4'd0);
    chk("udr_out_valid", out_valid, 1'b0);
    @(posedge clk);
    #1;

    // Single block: orig=k, cand=2k
    for (int k = 0; k < 16; k++) push(8'(k), 8'(2 * k));
    @(negedge clk);
    chk("sb_valid_latency", out_valid, 1'b0);
    @(posedge clk);
    #1;
    ENABLE_COUNTER = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("sb_out_valid", out_valid, 1'b1);
      chk("sb_counter", counter, i);
      chk("sb_orig", out_orig, i);
      chk("sb_cand", out_cand, 2 * i);
      chk("sb_last", block_last, i == 15);
    end
    @(posedge clk);
    #1;
    ENABLE_COUNTER = 1'b0;
    @(negedge clk);
    chk("sb_valid_fall", out_valid, 1'b0);
    chk("udr_sticky", underrun, 1'b1);
    @(posedge clk);
    #1;

    // Back-to-back: 32 pairs with continuous enable
    ENABLE_COUNTER = 1'b1;
    fork
      begin
        for (int k = 0; k < 32; k++) push(8'($urandom), 8'($urandom));
      end
      begin
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin
          @(negedge clk);
          n++;
        end
        chk("b2b_start", n < 100, 1'b1);
        for (int j = 0; j < 32; j++) begin
          if (j > 0) @(negedge clk);
          chk("b2b_no_bubble", out_valid, 1'b1);
          chk("b2b_last", block_last, (j == 15) || (j == 31));
        end
      end
    join
    @(posedge clk);
    #1;
    ENABLE_COUNTER = 1'b0;
    @(negedge clk);
    chk("b2b_end_valid", out_valid, 1'b0);
    @(posedge clk);
    #1;

    // Backpressure: fill both banks with no draining
    for (int k = 0; k < 32; k++) push(8'($urandom), 8'($urandom));
    @(negedge clk);
    chk("bp_ready_low", in_ready, 1'b0);
    @(posedge clk);
    #1;
    fork
      push(8'hA5, 8'h5A);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("bp_33rd_refused", in_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        run_en(16);
      end
    join
    run_en(17);
    for (int k = 0; k < 15; k++) push(8'($urandom), 8'($urandom));
    run_en(17);
    @(negedge clk);
    chk("bp_drained", out_valid, 1'b0);
    chk("bp_queue_empty", sb_q.size(), 0);
    @(posedge clk);
    #1;

    // Stall mid-block at counter 7
    for (int k = 0; k < 16; k++) begin
      st_o[k] = 8'($urandom);
      st_c[k] = 8'($urandom);
      push(st_o[k], st_c[k]);
    end
    @(posedge clk);
    #1;
    run_en(7);
    repeat (5) begin
      @(negedge clk);
      chk("stall_counter", counter, 4'd7);
      chk("stall_orig", out_orig, st_o[7]);
      chk("stall_cand", out_cand, st_c[7]);
    end
    @(posedge clk);
    #1;
    ENABLE_COUNTER = 1'b1;
    @(negedge clk);
    chk("resume_pre", counter, 4'd7);
    @(negedge clk);
    chk("resume_counter", counter, 4'd8);
    chk("resume_orig", out_orig, st_o[8]);
    repeat (8) @(posedge clk);
    #1;
    ENABLE_COUNTER = 1'b0;

    // Reset mid-operation: counter at 9, other bank half filled
    for (int k = 0; k < 16; k++) push(8'($urandom), 8'($urandom));
    for (int k = 0; k < 8; k++) push(8'($urandom), 8'($urandom));
    @(posedge clk);
    #1;
    run_en(9);
    chk("mid_counter9", counter, 4'd9);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 1'b1);
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_counter", counter, 4'd0);
    chk("mid_rst_last", block_last, 1'b0);
    chk("mid_rst_underrun", underrun, 1'b0);
    chk("mid_rst_orig", out_orig, 8'd0);
    @(negedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", in_ready, 1'b1);
    chk("post_rst_counter", counter, 4'd0);
    chk("post_rst_valid", out_valid, 1'b0);
    for (int k = 0; k < 16; k++) push(8'($urandom), 8'($urandom));
    run_en(17);
    @(negedge clk);
    chk("post_rst_drained", sb_q.size(), 0);
    @(posedge clk);
    #1;

    // Randomized traffic; the scoreboard checks every cycle
    repeat (600) begin
      in_valid       = 1'($urandom % 2);
      in_orig        = 8'($urandom);
      in_cand        = 8'($urandom);
      ENABLE_COUNTER = ($urandom % 4) != 0;
      @(posedge clk);
      #1;
    end
    in_valid       = 1'b0;
    ENABLE_COUNTER = 1'b0;
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
